// File: rtl/tdm_lane_scheduler.sv
// tdm_lane_scheduler: shares one byte-wide output among NUM_LANES lanes.
// Everything runs on clk8f; a 3-bit phase counter stands in for the divided
// clocks. Bytes are captured once per 8-cycle frame (phase 7 edge) and drained
// into four 2-cycle slots (phase 0/2/4/6 edges).
// Build option: define STRICT_PRIO_EN for fixed priority (lane 0 highest)
// instead of round-robin arbitration.
module tdm_lane_scheduler #(
  parameter int             NUM_LANES = 4,
  parameter int             DW        = 8,
  parameter logic [DW-1:0]  IDLE_BYTE = 8'hBC
) (
  input  logic                    clk8f,
  input  logic                    reset,
  input  logic [NUM_LANES-1:0]    in_valid,
  input  logic [NUM_LANES*DW-1:0] in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DW-1:0]           out_data,
  output logic [1:0]              out_lane,
  output logic                    frame_start,
  output logic [NUM_LANES-1:0]    ovf
);

  localparam int LW = 2;

  logic [2:0]           phase_q, phase_d;
  logic                 frame_start_q, frame_start_d;
  logic                 capture_en;
  logic                 decision_en;

  logic [NUM_LANES-1:0] pend_vec;
  logic [NUM_LANES-1:0] ovf_vec;
  logic [DW-1:0]        hold_arr [NUM_LANES];

  logic                 grant_vld;
  logic                 grant_take;
  logic [LW-1:0]        grant_idx;

  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [LW-1:0]        out_lane_q, out_lane_d;

`ifndef STRICT_PRIO_EN
  logic [LW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]           rr_sum;
  logic [LW-1:0]        rr_idx;
`endif

  // Capture and decision edges are mutually exclusive by construction:
  // capture only at phase 7 (odd), decisions only at even phases.
  assign capture_en  = (phase_q == 3'd7);
  assign decision_en = ~phase_q[0];

  // Phase advance; frame_start is high in the cycle that follows the phase-7 edge.
  always_comb begin
    phase_d       = phase_q + 3'd1;
    frame_start_d = capture_en;
  end

  // Phase counter and frame pulse registers.
  always_ff @(posedge clk8f) begin
    if (!reset) begin
      phase_q       <= 3'd0;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Per-lane holding register, pending flag and sticky overflow flag.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [DW-1:0] hold_q, hold_d;
    logic          pend_q, pend_d;
    logic          ovf_q, ovf_d;

    // Capture a new byte if the slot is free, otherwise drop it and flag overflow.
    always_comb begin
      hold_d = hold_q;
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (capture_en && in_valid[gi]) begin
        if (pend_q) begin
          ovf_d = 1'b1;
        end else begin
          hold_d = in_data[gi*DW +: DW];
          pend_d = 1'b1;
        end
      end
      if (grant_take && (grant_idx == LW'(gi))) begin
        pend_d = 1'b0;
      end
    end

    // Lane state registers; reset discards any held byte.
    always_ff @(posedge clk8f) begin
      if (!reset) begin
        hold_q <= '0;
        pend_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        pend_q <= pend_d;
        ovf_q  <= ovf_d;
      end
    end

    assign pend_vec[gi] = pend_q;
    assign ovf_vec[gi]  = ovf_q;
    assign hold_arr[gi] = hold_q;
  end

`ifdef STRICT_PRIO_EN
  // Fixed priority: lowest-index pending lane wins (descending scan, last hit wins).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (pend_vec[LW'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = LW'(k);
      end
    end
  end
`else
  // Round-robin: first pending lane at or after rr_ptr, modulo NUM_LANES.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_ptr_q} + 3'(k);
      if (rr_sum >= 3'(NUM_LANES)) begin
        rr_sum = rr_sum - 3'(NUM_LANES);
      end
      rr_idx = rr_sum[LW-1:0];
      if (pend_vec[rr_idx]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end
`endif

  assign grant_take = decision_en & out_ready & grant_vld;

  // Slot decision: load a granted byte or idle; outputs hold between decisions.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
`ifndef STRICT_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    if (decision_en) begin
      if (grant_take) begin
        out_valid_d = 1'b1;
        out_data_d  = hold_arr[grant_idx];
        out_lane_d  = grant_idx;
`ifndef STRICT_PRIO_EN
        rr_ptr_d    = (grant_idx == LW'(NUM_LANES - 1)) ? '0 : grant_idx + LW'(1);
`endif
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = IDLE_BYTE;
      end
    end
  end

  // Output slot registers and arbitration pointer.
  always_ff @(posedge clk8f) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= IDLE_BYTE;
      out_lane_q  <= '0;
`ifndef STRICT_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
`ifndef STRICT_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_lane    = out_lane_q;
  assign frame_start = frame_start_q;
  assign ovf         = ovf_vec;

endmodule

// File: doc/tdm_lane_scheduler.md
Name: tdm_lane_scheduler

Overview:
- Time-division scheduler that shares one byte-wide output channel among NUM_LANES requester lanes.
- Runs entirely on clk8f. An internal 3-bit phase counter replaces the divided clocks as enables, so one clkf period is 8 clk8f cycles and one output slot is 2 clk8f cycles (clk4f rate).
- Captures one byte per lane per clkf period and drains pending bytes into 4 slots per period, round-robin.
- Sits between the lane sources and the serializer/PHY stage.

Parameters:
- NUM_LANES, 4, number of requester lanes (legal 1..4).
- DW, 8, byte width of each lane and of the output.
- IDLE_BYTE, 8'hBC, value driven on out_data when no byte is granted.

Ports:
- clk8f  input  1  fundamental clock (8f Hz).
- reset  input  1  synchronous, active-low reset, sampled on clk8f.
- in_valid  input  NUM_LANES  per-lane byte-valid, held stable for one clkf period.
- in_data  input  NUM_LANES*DW  lane i byte at bits [i*DW +: DW].
- out_ready  input  1  downstream can accept a byte in the next slot.
- out_valid  output  1  out_data carries a granted lane byte.
- out_data  output  DW  granted byte, or IDLE_BYTE.
- out_lane  output  2  index of the granted lane.
- frame_start  output  1  one-cycle pulse marking the first cycle of each clkf period.
- ovf  output  NUM_LANES  sticky per-lane overflow flags.

Behaviour:
- Reset (reset==0 at a clk8f edge):
  - phase=0, rr_ptr=0, all pend=0.
  - out_valid=0, out_data=IDLE_BYTE, out_lane=0, frame_start=0, ovf=0.
  - Any in-flight held bytes are discarded.
- Phase counter:
  - phase increments by 1 on every clk8f edge and wraps 7->0.
  - frame_start is registered: it is 1 during the cycle in which phase==0, else 0.
- Capture edge (edge while phase==7):
  - For each lane i with in_valid[i]=1 and pend[i]=0: hold[i]<=byte i, pend[i]<=1.
  - If pend[i]=1 already: the new byte is dropped, hold[i] is unchanged, and ovf[i]<=1.
  - ovf bits stay set until reset.
- Decision edge (edge while phase[0]==0, i.e. phase 0, 2, 4, 6):
  - If out_ready=1 and any pend=1: grant lane g, the first pending lane searching from rr_ptr upward modulo NUM_LANES.
    - out_valid<=1, out_data<=hold[g], out_lane<=g.
    - pend[g]<=0, rr_ptr<=(g+1) mod NUM_LANES.
  - Otherwise: out_valid<=0, out_data<=IDLE_BYTE, out_lane unchanged, rr_ptr unchanged.
  - Outputs hold for 2 cycles (one slot).
  - out_ready is sampled only at decision edges.
- Capture and decision edges never coincide, so there are no simultaneous set/clear conflicts on pend.
- Latency: a byte captured at the phase-7 edge appears on out_data after the next edge (phase 0 decision) at the earliest, i.e. 1 clk8f cycle later.
- Worst-case wait with continuous out_ready and all lanes pending: NUM_LANES slots.
- Unused lanes (index >= NUM_LANES) do not exist; out_lane never exceeds NUM_LANES-1.

Optional Feature:
- Macro STRICT_PRIO_EN.
- When defined: the decision edge always grants the lowest-index pending lane (lane 0 highest priority), and rr_ptr is neither used nor updated.
- When undefined: round-robin as specified above.
- Capture, overflow and reset behaviour are identical in both builds.

Test Plan:
- Reset held low 3 cycles, then released -> out_valid=0, out_data=8'hBC, ovf=0, frame_start first high when phase==0, then every 8 cycles.
- All 4 lanes valid with bytes 8'h11/22/33/44, out_ready=1 -> out_data sequence 11,22,33,44, each held 2 cycles, starting 1 cycle after the phase-7 edge; out_lane 0,1,2,3.
- Only lane 2 valid (8'hA5), out_ready=1 -> one slot with out_valid=1, out_data=A5, out_lane=2; remaining 3 slots show IDLE_BYTE and out_valid=0.
- out_ready=0 for two full periods while lane 1 is sent 8'h01 then 8'h02 -> ovf[1]=1, and after out_ready=1 out_data=01 (02 is dropped).
- Round-robin fairness: lanes 0 and 3 continuously valid, out_ready toggled to allow 1 grant per period -> grants alternate 0,3,0,3. With STRICT_PRIO_EN, the same stimulus yields 0,0,0,… and lane 3 overflows.
- Reset asserted at phase 3 with 2 lanes pending -> next cycle out_valid=0, pend cleared, and no stale byte is emitted after release.
